// File: rtl/bus_pkg.sv
// Shared bus definitions: ID width, the broadcast ID and destination-field extraction.
// Consumers select the self-filter option with the BUS_SRC_SELF_FILTER_EN macro.
package bus_pkg;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

   // Widest packet that dest_of can accept; narrower packets are zero-extended.
   localparam int PKT_W_MAX = 256;
   typedef logic [PKT_W_MAX-1:0] pkt_wide_t;

   // Returns the top ID_W bits of a packet whose MSB sits at position msb.
   function automatic logic [ID_W-1:0] dest_of(input pkt_wide_t pkt,
                                                input logic [$clog2(PKT_W_MAX)-1:0] msb);
      return pkt[msb -: ID_W];
   endfunction

endpackage

// File: rtl/bus_src_fifo_mem.sv
// Register array for the source FIFO: one synchronous write port and one
// asynchronous read port, so the head entry is visible in the same cycle.
module bus_src_fifo_mem
   import bus_pkg::*;
#(
   parameter int width = 16,
   parameter int depth = 8,
   localparam int AW = $clog2(depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem [depth];

   // Storage is never cleared; the pointers decide which entries are live.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_src_fifo.sv
// Per-terminal source FIFO feeding the bus arbiter. First-word-fall-through head
// on D_pop, sticky overflow/underflow flags.
// Optional macro BUS_SRC_SELF_FILTER_EN drops pushes addressed to this terminal's
// own id (broadcasts are always kept) and counts them in self_drop_cnt.
module bus_src_fifo
   import bus_pkg::*;
#(
   parameter int              pckg_sz   = 16,
   parameter int              depth     = 8,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
   parameter logic [ID_W-1:0] id        = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [pckg_sz-1:0]         D_push,
   output logic                       full,
   input  logic                       pop,
   output logic [pckg_sz-1:0]         D_pop,
   output logic                       pndng,
   output logic [$clog2(depth+1)-1:0] count,
   output logic                       ovf,
   output logic                       udf
`ifdef BUS_SRC_SELF_FILTER_EN
   ,
   output logic [15:0]                self_drop_cnt
`endif
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth+1);

   typedef logic [pckg_sz-1:0] pkt_t;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   pkt_t          head;
   logic          push_ok;
   logic          do_wr;
   logic          do_rd;

`ifdef BUS_SRC_SELF_FILTER_EN
   logic [ID_W-1:0] dest;
   logic            self_hit;

   assign dest     = dest_of(pkt_wide_t'(D_push), ($clog2(PKT_W_MAX))'(pckg_sz-1));
   assign self_hit = (dest == id) && (dest != broadcast);
   assign push_ok  = push && !self_hit;

   // Saturating count of pushes discarded because they target this terminal.
   always_ff @(posedge clk) begin
      if (!reset)
         self_drop_cnt <= '0;
      else if (push && self_hit && (self_drop_cnt != 16'hFFFF))
         self_drop_cnt <= self_drop_cnt + 16'd1;
   end
`else
   assign push_ok = push;
`endif

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_rd = pop && pndng;
   assign do_wr = push_ok && (!full || pop);

   assign pndng = (count != '0);
   assign full  = (count == CW'(depth));
   assign D_pop = pndng ? head : '0;

   bus_src_fifo_mem #(
      .width (pckg_sz),
      .depth (depth)
   ) u_mem (
      .clk   (clk),
      .we    (do_wr && reset),
      .waddr (wr_ptr),
      .wdata (D_push),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Pointers, occupancy and sticky error flags; reset wins over push/pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd)
            count <= count + 1'b1;
         else if (do_rd && !do_wr)
            count <= count - 1'b1;
         if (push_ok && full && !pop) ovf <= 1'b1;
         if (pop && !pndng)           udf <= 1'b1;
      end
   end

endmodule
